stb_delay_sweep: RTL and testbench
==================================

// Module: stb_delay_sweep
// PURPOSE
//  Consumes the strobe and measured period from the strobe generator. Sweeps a delayed strobe
//  across the period and counts comparator hits at each delay point. Emits one (delay, hits)
//  result per point over a valid/ready stream to the measure-unit result path.
//  stb_i is same-domain; cmp_i is asynchronous.
// PARAMETERS
//  T_CNT_WIDTH    32  width of period, delay and time counters
//  HIT_CNT_WIDTH  16  width of n_avg_i and hit counter
//  SYNC_STAGES    2   synchronizer depth for cmp_i (>=2)
//  SAMPLE_LAT     3   cycles from dly_stb_o pulse to cmp sample (>=SYNC_STAGES)
// PORTS
//  clk_i         in   1    single clock; all logic on posedge
//  rst_i         in   1    synchronous, active-high reset
//  stb_i         in   1    strobe from generator; rising edge = period start
//  period_i      in   T    measured period (cycles); valid while period_vld_i=1
//  period_vld_i  in   1    period measurement valid
//  start_i       in   1    1-cycle start pulse; ignored while busy_o=1
//  abort_i       in   1    stop sweep, drop pending result, return to IDLE
//  dly_start_i   in   T    first delay; sampled at start
//  dly_end_i     in   T    last delay (inclusive); sampled at start
//  dly_step_i    in   T    delay increment; sampled at start
//  n_avg_i       in   H    strobes per point; sampled at start
//  cmp_i         in   1    asynchronous comparator output
//  dly_stb_o     out  1    1-cycle delayed strobe
//  busy_o        out  1    sweep in progress
//  done_o        out  1    1-cycle pulse: sweep finished, errored or aborted
//  err_o         out  1    sticky config/timeout error; cleared by next accepted start
//  res_valid_o   out  1    result valid
//  res_ready_i   in   1    result consumer ready
//  res_dly_o     out  T    delay of this result point
//  res_hits_o    out  H    count of samples with cmp=1 at this point
// BEHAVIOUR
//  Reset: all outputs 0; FSM IDLE; counters 0. Reset mid-sweep discards everything.
//  Edge: stb_rise = stb_i & ~stb_q (stb_q is a 1-cycle delayed copy).
//  FSM IDLE->ARM->DELAY->SAMPLE->(ARM | OUT); OUT->ARM | IDLE.
//  IDLE: on start_i, latch config and clear err_o. Config is bad if any holds:
//    period_vld_i=0; dly_step_i=0; n_avg_i=0; dly_start_i>dly_end_i; dly_end_i>=period_i.
//    Bad config: err_o<=1, done_o pulse next cycle, stay IDLE, busy_o stays 0.
//    Good config: cur_dly<=dly_start_i, hits<=0, n<=0, busy_o<=1, go ARM.
//  ARM: wait for stb_rise. Timeout if t_cnt reaches all-ones: err_o<=1, done_o pulse, go IDLE.
//  DELAY: t_cnt=0 on the cycle after stb_rise (cycle E), incrementing each cycle.
//    dly_stb_o=1 exactly in cycle E+1+cur_dly; then go SAMPLE.
//    A stb_rise in DELAY is an error (period shrank): err_o<=1, done_o, go IDLE.
//  SAMPLE: sample cmp_sync SAMPLE_LAT cycles after the dly_stb_o cycle.
//    hits += cmp_sync (saturating); n += 1.
//    If n==n_avg go OUT; else go ARM. A stb_rise during SAMPLE counts as the next arm edge.
//  OUT: res_valid_o=1 with res_dly_o=cur_dly and res_hits_o=hits.
//    Outputs are held stable until res_ready_i; stb edges are ignored while stalled.
//    On handshake (valid&ready): nxt = cur_dly + step, computed at T+1 bits (no wrap).
//      nxt > dly_end: busy_o<=0, done_o pulse, go IDLE.
//      Otherwise: cur_dly<=nxt, hits<=0, n<=0, go ARM.
//  abort_i (any state except IDLE): res_valid_o<=0, busy_o<=0, done_o pulse, go IDLE;
//    err_o unchanged.
//  Simultaneous abort_i and handshake: abort wins; the result counts as consumed.
//  start_i together with rst_i: reset wins.
//  Points emitted = floor((end-start)/step)+1.
// TESTING
//  1. period=100, start=10, end=30, step=10, n_avg=4, cmp=1 -> 3 results (10,4)(20,4)(30,4), done_o once.
//  2. Single stb_rise at cycle E, dly=0 / dly=99 -> dly_stb_o in cycle E+1 / E+100, width 1 cycle.
//  3. start=0, end=95, step=10, period=100 -> 10 points ending at delay 90; last nxt=100>95 terminates.
//  4. dly_end=100, period=100 (or step=0, or period_vld=0) -> err_o=1, done_o, no results, busy_o=0.
//  5. res_ready_i low for 50 cycles in OUT -> res_* stable, strobes ignored; next point resumes after handshake.
//  6. abort_i mid-DELAY, and rst_i mid-sweep -> IDLE, res_valid_o=0, busy_o=0; new start runs cleanly.

Source files
------------

// File: rtl/stb_delay_sweep.sv
// Delay sweep engine: emits a delayed strobe at each delay point in a range.
// It counts comparator hits per point and streams out one (delay, hits) result per point.
module stb_delay_sweep #(
  parameter int T_CNT_WIDTH   = 32,
  parameter int HIT_CNT_WIDTH = 16,
  parameter int SYNC_STAGES   = 2,
  parameter int SAMPLE_LAT    = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     stb_i,
  input  logic [T_CNT_WIDTH-1:0]   period_i,
  input  logic                     period_vld_i,
  input  logic                     start_i,
  input  logic                     abort_i,
  input  logic [T_CNT_WIDTH-1:0]   dly_start_i,
  input  logic [T_CNT_WIDTH-1:0]   dly_end_i,
  input  logic [T_CNT_WIDTH-1:0]   dly_step_i,
  input  logic [HIT_CNT_WIDTH-1:0] n_avg_i,
  input  logic                     cmp_i,
  output logic                     dly_stb_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o,
  output logic                     res_valid_o,
  input  logic                     res_ready_i,
  output logic [T_CNT_WIDTH-1:0]   res_dly_o,
  output logic [HIT_CNT_WIDTH-1:0] res_hits_o
);

  localparam int T     = T_CNT_WIDTH;
  localparam int H     = HIT_CNT_WIDTH;
  localparam int LAT_W = $clog2(SAMPLE_LAT + 1);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_DELAY, S_SAMPLE, S_OUT} state_e;

  state_e             state_q;
  logic               stb_q;
  logic [SYNC_STAGES-1:0] cmp_sync_q;
  logic [T-1:0]       t_cnt_q, cur_dly_q, end_q, step_q;
  logic [H-1:0]       n_avg_q, hits_q, n_q;
  logic [LAT_W-1:0]   lat_q;
  logic               pend_q;
  logic               dly_stb_q, busy_q, done_q, err_q, res_valid_q;

  logic               stb_rise;
  logic               cmp_sync;
  logic [T:0]         nxt_dly_d;
  logic               cfg_bad_d;
  logic [H-1:0]       hits_d, n_d;

  assign stb_rise = stb_i & ~stb_q;
  assign cmp_sync = cmp_sync_q[SYNC_STAGES-1];

  // NOTE: every signal written here gets a value before any condition, so no latch is inferred.
  always_comb begin
    nxt_dly_d = {1'b0, cur_dly_q} + {1'b0, step_q};
    cfg_bad_d = !period_vld_i || (dly_step_i == '0) || (n_avg_i == '0) ||
                (dly_start_i > dly_end_i) || (dly_end_i >= period_i);
    hits_d    = hits_q;
    if (cmp_sync && (hits_q != '1)) hits_d = hits_q + H'(1);
    n_d       = n_q + H'(1);
  end

  // NOTE: non-blocking assignments keep every register update order-independent within the edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stb_q      <= 1'b0;
      cmp_sync_q <= '0;
    end else begin
      stb_q      <= stb_i;
      cmp_sync_q <= {cmp_sync_q[SYNC_STAGES-2:0], cmp_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      t_cnt_q     <= '0;
      cur_dly_q   <= '0;
      end_q       <= '0;
      step_q      <= '0;
      n_avg_q     <= '0;
      hits_q      <= '0;
      n_q         <= '0;
      lat_q       <= '0;
      pend_q      <= 1'b0;
      dly_stb_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      dly_stb_q <= 1'b0;
      if (abort_i && (state_q != S_IDLE)) begin
        res_valid_q <= 1'b0;
        busy_q      <= 1'b0;
        done_q      <= 1'b1;
        pend_q      <= 1'b0;
        state_q     <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: if (start_i) begin
            err_q  <= cfg_bad_d;
            done_q <= cfg_bad_d;
            if (!cfg_bad_d) begin
              cur_dly_q <= dly_start_i;
              end_q     <= dly_end_i;
              step_q    <= dly_step_i;
              n_avg_q   <= n_avg_i;
              hits_q    <= '0;
              n_q       <= '0;
              t_cnt_q   <= '0;
              pend_q    <= 1'b0;
              busy_q    <= 1'b1;
              state_q   <= S_ARM;
            end
          end
          S_ARM: begin
            if (stb_rise) begin
              t_cnt_q <= '0;
              state_q <= S_DELAY;
            end else if (t_cnt_q == '1) begin
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              t_cnt_q <= t_cnt_q + T'(1);
            end
          end
          S_DELAY: begin
            // Firing wins over a coincident edge; that edge becomes the next arm edge.
            if (t_cnt_q >= cur_dly_q) begin
              dly_stb_q <= 1'b1;
              lat_q     <= '0;
              pend_q    <= stb_rise;
              t_cnt_q   <= '0;
              state_q   <= S_SAMPLE;
            end else if (stb_rise) begin
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              t_cnt_q <= t_cnt_q + T'(1);
            end
          end
          S_SAMPLE: begin
            // While an edge is pending, t_cnt_q tracks time since that edge's cycle E.
            if (stb_rise) begin
              pend_q  <= 1'b1;
              t_cnt_q <= '0;
            end else begin
              t_cnt_q <= t_cnt_q + T'(1);
            end
            if (lat_q == LAT_W'(SAMPLE_LAT)) begin
              hits_q <= hits_d;
              n_q    <= n_d;
              pend_q <= 1'b0;
              if (n_d == n_avg_q) begin
                res_valid_q <= 1'b1;
                state_q     <= S_OUT;
              end else if (stb_rise || pend_q) begin
                state_q <= S_DELAY;
              end else begin
                t_cnt_q <= '0;
                state_q <= S_ARM;
              end
            end else begin
              lat_q <= lat_q + LAT_W'(1);
            end
          end
          S_OUT: if (res_ready_i) begin
            res_valid_q <= 1'b0;
            if (nxt_dly_d > {1'b0, end_q}) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              cur_dly_q <= nxt_dly_d[T-1:0];
              hits_q    <= '0;
              n_q       <= '0;
              t_cnt_q   <= '0;
              state_q   <= S_ARM;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign dly_stb_o   = dly_stb_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign res_valid_o = res_valid_q;
  assign res_dly_o   = cur_dly_q;
  assign res_hits_o  = hits_q;

endmodule

// File: tb/tb_stb_delay_sweep.sv
// Bench for stb_delay_sweep: config vector table, directed corner sequences, and randomized sweeps
// checked against an event-level model of strobe rises, sample instants and result points.
module tb_stb_delay_sweep;
  localparam int T  = 32;
  localparam int H  = 16;
  localparam int SS = 2;
  localparam int SL = 3;
  localparam int HIST = 65536;

  logic         clk_i = 1'b0;
  logic         rst_i, stb_i, period_vld_i, start_i, abort_i, cmp_i, res_ready_i;
  logic [T-1:0] period_i, dly_start_i, dly_end_i, dly_step_i;
  logic [H-1:0] n_avg_i;
  logic         dly_stb_o, busy_o, done_o, err_o, res_valid_o;
  logic [T-1:0] res_dly_o;
  logic [H-1:0] res_hits_o;

  stb_delay_sweep #(.T_CNT_WIDTH(T), .HIT_CNT_WIDTH(H), .SYNC_STAGES(SS), .SAMPLE_LAT(SL)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .stb_i(stb_i), .period_i(period_i), .period_vld_i(period_vld_i),
    .start_i(start_i), .abort_i(abort_i), .dly_start_i(dly_start_i), .dly_end_i(dly_end_i),
    .dly_step_i(dly_step_i), .n_avg_i(n_avg_i), .cmp_i(cmp_i), .dly_stb_o(dly_stb_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .res_valid_o(res_valid_o),
    .res_ready_i(res_ready_i), .res_dly_o(res_dly_o), .res_hits_o(res_hits_o));

  always #5 clk_i = ~clk_i;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   rise_hist [HIST];
  bit   cmp_hist  [HIST];
  logic stb_prev  = 1'b0;

  typedef struct {
    int per; bit vld; int ds; int de; int st; int na; bit exp_err;
  } cfg_vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  // Cycle c runs from posedge c to posedge c+1; outputs are read and inputs driven at its negedge.
  task automatic tick();
    @(negedge clk_i);
    cyc++;
  endtask

  task automatic drive(input logic stb, input logic cmp, input logic rdy);
    stb_i = stb;
    cmp_i = cmp;
    res_ready_i = rdy;
    if (cyc < HIST) begin
      rise_hist[cyc] = stb & ~stb_prev;
      cmp_hist[cyc]  = cmp;
    end
    stb_prev = stb;
  endtask

  task automatic set_cfg(input int per, input bit vld, input int ds, input int de, input int st,
                         input int na);
    period_i = T'(per); period_vld_i = vld; dly_start_i = T'(ds);
    dly_end_i = T'(de); dly_step_i = T'(st); n_avg_i = H'(na);
  endtask

  // Runs one complete sweep and scores every result point against the model.
  task automatic run_sweep(input string tag, input int per, input int ds, input int de, input int st,
                           input int na, input int smin, input int smax, input int cmp_mode,
                           input bit single);
    int npts, k, done_cnt, post, stall_len, stall_cnt, budget, t0, idx, exp_hits;
    bit in_res, stable_ok, width_ok, prev_pulse;
    logic [T-1:0] cap_dly;
    logic [H-1:0] cap_hits;
    logic rdy, stbv, cmpv;
    int pulses[$];
    npts = (de - ds) / st + 1;
    k = 0; done_cnt = 0; post = -1; stall_len = 0; stall_cnt = 0;
    in_res = 0; stable_ok = 1; width_ok = 1; prev_pulse = 0;
    cap_dly = '0; cap_hits = '0;
    budget = npts * (na + 2) * per + npts * (smax + 10) + 400;
    tick();
    set_cfg(per, 1'b1, ds, de, st, na);
    start_i = 1'b1;
    t0 = cyc;
    drive(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < budget && post != 0; i++) begin
      tick();
      start_i = 1'b0;
      if (post > 0) post--;
      if (dly_stb_o) begin
        // Pulse must sit at R+2+delay: E is the cycle after rise R, pulse lands in E+1+delay.
        idx = cyc - 2 - (ds + k * st);
        check({tag, "_pulse_align"}, (idx >= 0) ? rise_hist[idx] : 1'b0, 1);
        pulses.push_back(cyc);
        if (prev_pulse) width_ok = 0;
      end
      prev_pulse = dly_stb_o;
      if (done_o) begin
        done_cnt++;
        if (post < 0) post = 3;
      end
      rdy = 1'($urandom_range(0, 1));
      if (res_valid_o) begin
        if (!in_res) begin
          in_res = 1; cap_dly = res_dly_o; cap_hits = res_hits_o; stable_ok = 1;
          stall_len = $urandom_range(smin, smax); stall_cnt = 0;
        end else if (res_dly_o !== cap_dly || res_hits_o !== cap_hits) begin
          stable_ok = 0;
        end
        if (dly_stb_o) stable_ok = 0;
        if (stall_cnt < stall_len) begin
          rdy = 1'b0;
          stall_cnt++;
        end else begin
          rdy = 1'b1;
          exp_hits = 0;
          foreach (pulses[j]) exp_hits += int'(cmp_hist[pulses[j] + SL - SS]);
          check({tag, "_res_dly"}, res_dly_o, ds + k * st);
          check({tag, "_res_hits"}, res_hits_o, exp_hits);
          check({tag, "_samples"}, pulses.size(), na);
          check({tag, "_res_stable"}, stable_ok, 1);
          k++;
          pulses.delete();
          in_res = 0;
        end
      end
      stbv = single ? (cyc == t0 + 5) : ((cyc % per) == 0);
      cmpv = (cmp_mode == 0) ? 1'b1 : (cmp_mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
      drive(stbv, cmpv, rdy);
    end
    check({tag, "_points"}, k, npts);
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_busy_end"}, busy_o, 0);
    check({tag, "_err_end"}, err_o, 0);
    check({tag, "_pulse_width"}, width_ok, 1);
  endtask

  initial begin
    #50_000_000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    cfg_vec_t vecs[8];
    int aborted_pulses;
    bit reached;
    vecs[0] = '{100, 1, 10,  30, 10, 4, 0};
    vecs[1] = '{100, 1,  0, 100, 10, 4, 1};
    vecs[2] = '{100, 1, 10,  30,  0, 4, 1};
    vecs[3] = '{100, 0, 10,  30, 10, 4, 1};
    vecs[4] = '{100, 1, 10,  30, 10, 0, 1};
    vecs[5] = '{100, 1, 40,  30, 10, 4, 1};
    vecs[6] = '{100, 1, 99,  99,  1, 1, 0};
    vecs[7] = '{100, 1, 30,  30,  5, 2, 0};

    rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0;
    set_cfg(0, 1'b0, 0, 0, 0, 0);
    drive(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      drive(1'b0, 1'b0, 1'b0);
    end
    check("reset_flags", {dly_stb_o, busy_o, done_o, err_o, res_valid_o}, 0);
    check("reset_res_dly", res_dly_o, 0);
    check("reset_res_hits", res_hits_o, 0);
    // A start presented together with reset must be ignored.
    set_cfg(100, 1'b1, 10, 30, 10, 4);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    rst_i = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    check("start_in_reset", busy_o, 0);

    // Config acceptance table; accepted sweeps are aborted straight away in ARM.
    foreach (vecs[v]) begin
      tick();
      set_cfg(vecs[v].per, vecs[v].vld, vecs[v].ds, vecs[v].de, vecs[v].st, vecs[v].na);
      start_i = 1'b1;
      drive(1'b0, 1'b0, 1'b0);
      tick();
      start_i = 1'b0;
      check($sformatf("cfg%0d_err", v), err_o, vecs[v].exp_err);
      check($sformatf("cfg%0d_done", v), done_o, vecs[v].exp_err);
      check($sformatf("cfg%0d_busy", v), busy_o, !vecs[v].exp_err);
      abort_i = !vecs[v].exp_err;
      drive(1'b0, 1'b0, 1'b0);
      tick();
      abort_i = 1'b0;
      check($sformatf("cfg%0d_done2", v), done_o, !vecs[v].exp_err);
      check($sformatf("cfg%0d_err_sticky", v), err_o, vecs[v].exp_err);
      drive(1'b0, 1'b0, 1'b0);
    end

    run_sweep("t1", 100, 10, 30, 10, 4, 0, 0, 0, 1'b0);
    run_sweep("t2_d0", 100, 0, 0, 1, 1, 0, 0, 0, 1'b1);
    run_sweep("t2_d99", 100, 99, 99, 1, 1, 0, 0, 0, 1'b1);
    run_sweep("t2_d99_run", 100, 99, 99, 1, 3, 0, 1, 1, 1'b0);
    run_sweep("t3", 100, 0, 95, 10, 2, 0, 2, 1, 1'b0);
    run_sweep("t5", 40, 5, 25, 10, 2, 50, 50, 1, 1'b0);

    // Abort while waiting out the delay of the first point.
    tick();
    set_cfg(100, 1'b1, 50, 50, 1, 1);
    start_i = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      start_i = 1'b0;
      drive(i == 3, 1'b1, 1'b1);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      drive(1'b0, 1'b1, 1'b1);
    end
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    check("abort_done", done_o, 1);
    check("abort_flags", {busy_o, res_valid_o, err_o}, 0);
    aborted_pulses = 0;
    for (int i = 0; i < 120; i++) begin
      drive((i % 30) == 0, 1'b1, 1'b1);
      tick();
      aborted_pulses += int'(dly_stb_o) + int'(res_valid_o);
    end
    check("abort_quiet", aborted_pulses, 0);
    drive(1'b0, 1'b0, 1'b0);

    // Reset while a result is stalled in OUT.
    tick();
    set_cfg(30, 1'b1, 5, 5, 1, 1);
    start_i = 1'b1;
    drive(1'b0, 1'b1, 1'b0);
    reached = 0;
    for (int i = 0; i < 200 && !reached; i++) begin
      tick();
      start_i = 1'b0;
      reached = res_valid_o;
      drive((cyc % 30) == 0, 1'b1, 1'b0);
    end
    check("rst_reach_out", reached, 1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    check("rst_mid_flags", {dly_stb_o, busy_o, done_o, err_o, res_valid_o}, 0);
    check("rst_mid_res", {res_dly_o, res_hits_o}, 0);
    run_sweep("post_rst", 100, 10, 30, 10, 4, 0, 0, 0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      int per, de, ds, st, na;
      per = $urandom_range(12, 40);
      de  = $urandom_range(0, per - 1);
      ds  = $urandom_range(0, de);
      st  = $urandom_range(3, 12);
      na  = $urandom_range(1, 3);
      run_sweep($sformatf("rnd%0d", r), per, ds, de, st, na, 0, 3, 1, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
